// File: rtl/dmem_pkg.sv
// Shared encodings for the MIPS MEM-stage data memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: size encodings, FSM state enum, byte-lane constants and a lane-enable helper.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam int LANES  = 4;
    localparam int LANE_W = 8;

    // Lane-enable bit i covers word bits [8i+7:8i]; big-endian puts offset 0 in lane 3.
    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;

    function automatic logic [3:0] byte_lane_be(input logic [1:0] off);
        return BE_WORD & (4'b1000 >> off);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Big-endian byte-lane steering for stores and loads, plus the misalignment flag.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: req_* describe the incoming access (store lanes, misalignment);
//        ld_* describe the registered load (lane pick, sign/zero extension).
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_off,
    input  logic [31:0] req_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    output logic        misaligned,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_signed,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    always_comb begin
        st_be      = BE_NONE;
        st_wdata   = req_wdata;
        misaligned = 1'b0;
        case (req_size)
            SZ_BYTE: begin
                st_be    = byte_lane_be(req_off);
                st_wdata = {4{req_wdata[7:0]}};
            end
            SZ_HALF: begin
                st_be      = req_off[1] ? BE_HALF_LO : BE_HALF_HI;
                st_wdata   = {2{req_wdata[15:0]}};
                misaligned = req_off[0];
            end
            SZ_WORD: begin
                st_be      = BE_WORD;
                misaligned = |req_off;
            end
            default: ;
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = 8'h00;
        case (ld_off)
            2'd0:    ld_byte = ld_word[31:24];
            2'd1:    ld_byte = ld_word[23:16];
            2'd2:    ld_byte = ld_word[15:8];
            default: ld_byte = ld_word[7:0];
        endcase
        ld_half = ld_off[1] ? ld_word[15:0] : ld_word[31:16];

        case (ld_size)
            SZ_BYTE: ld_data = ld_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
            SZ_HALF: ld_data = ld_signed ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/mips_data_mem.sv
// Handshaked big-endian data memory for the MIPS MEM stage, byte/half/word with error reporting.
// Latency: response valid 1 cycle after the accept edge; 1 request/cycle while rsp_ready is high.
// Backpressure: while rsp_valid && !rsp_ready the response holds and req_ready stays low.
// Ports: clk, rst (async active-low); req_valid/req_ready/req_we/req_size/req_signed/req_addr/req_wdata;
//        rsp_valid/rsp_ready/rsp_rdata/rsp_err; init_done.
// Build option: DMEM_RESET_CLEAR_EN adds a post-reset sweep that zeroes every word.
module mips_data_mem
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        init_done
);

    localparam int         AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    state_t         state;
    logic [31:0]    mem [DEPTH_WORDS];
    logic [AW-1:0]  idx;
    logic [AW-1:0]  clr_cnt;
    logic           clr_we;
    logic           in_range, misaligned, err, accept, st_we;
    logic [3:0]     st_be;
    logic [31:0]    st_wdata, ld_data, rd_word;
    logic [1:0]     ld_size, ld_off;
    logic           ld_signed, ld_ok;

    // BASE_ADDR is word aligned, so the low address bits are the lane offset directly.
    assign idx      = AW'((req_addr - BASE_ADDR) >> 2);
    assign in_range = ({1'b0, req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, req_addr} < LIMIT);
    assign err      = (req_size == SZ_RSVD) || misaligned || !in_range;

    assign req_ready = (state == ST_IDLE) || (state == ST_RESP && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign st_we     = accept && req_we && !err;

    // Loads only drive data; stores and errors respond with zero.
    assign rsp_rdata = ld_ok ? ld_data : 32'h0;

    dmem_lane_align u_align (
        .req_size   (req_size),
        .req_off    (req_addr[1:0]),
        .req_wdata  (req_wdata),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .misaligned (misaligned),
        .ld_size    (ld_size),
        .ld_off     (ld_off),
        .ld_signed  (ld_signed),
        .ld_word    (rd_word),
        .ld_data    (ld_data)
    );

`ifdef DMEM_RESET_CLEAR_EN
    localparam state_t RESET_ST = ST_CLEAR;
    logic init_done_q;
    assign clr_we    = (state == ST_CLEAR);
    assign init_done = init_done_q;
`else
    localparam state_t RESET_ST = ST_IDLE;
    assign clr_we    = 1'b0;
    assign clr_cnt   = '0;
    assign init_done = 1'b1;
`endif

    // Array port: sweep write, masked store write, and the registered read at accept.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_cnt] <= '0;
        end else if (st_we) begin
            for (int i = 0; i < LANES; i++) begin
                if (st_be[i]) mem[idx][i*LANE_W +: LANE_W] <= st_wdata[i*LANE_W +: LANE_W];
            end
        end
        if (accept) rd_word <= mem[idx];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RESET_ST;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            ld_ok     <= 1'b0;
            ld_size   <= SZ_WORD;
            ld_off    <= 2'd0;
            ld_signed <= 1'b0;
`ifdef DMEM_RESET_CLEAR_EN
            clr_cnt     <= '0;
            init_done_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_CLEAR: begin
`ifdef DMEM_RESET_CLEAR_EN
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == AW'(DEPTH_WORDS - 1)) begin
                        state       <= ST_IDLE;
                        init_done_q <= 1'b1;
                    end
`else
                    state <= ST_IDLE;
`endif
                end
                ST_IDLE, ST_RESP: begin
                    if (accept) begin
                        state     <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= err;
                        ld_ok     <= !req_we && !err;
                        ld_size   <= req_size;
                        ld_off    <= req_addr[1:0];
                        ld_signed <= req_signed;
                    end else if (state == ST_RESP && rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        ld_ok     <= 1'b0;
                    end
                end
                default: state <= RESET_ST;
            endcase
        end
    end

endmodule
